// File: rtl/bcd_convert_arbiter_if.sv
// Request/result bundle between the two requesters and the shared BCD engine.
// The master side drives the requests; the slave side is the engine.
interface bcd_convert_arbiter_if #(
  parameter int WIDTH  = 20,
  parameter int DIGITS = 6
);
  logic                req0;
  logic [WIDTH-1:0]    bin0;
  logic                req1;
  logic [WIDTH-1:0]    bin1;
  logic                ack0;
  logic                ack1;
  logic                busy;
  logic                done;
  logic                done_id;
  logic [4*DIGITS-1:0] bcd_out;
  logic                ovf;

  modport master (
    output req0, bin0, req1, bin1,
    input  ack0, ack1, busy, done, done_id, bcd_out, ovf
  );

  modport slave (
    input  req0, bin0, req1, bin1,
    output ack0, ack1, busy, done, done_id, bcd_out, ovf
  );
endinterface

// File: rtl/bcd_convert_arbiter.sv
// Shared double-dabble binary-to-BCD engine with a two-way round-robin arbiter.
// One operand bit per cycle; the result saturates to all nines when it overflows DIGITS.
module bcd_convert_arbiter #(
  parameter int WIDTH  = 20,
  parameter int DIGITS = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  bcd_convert_arbiter_if.slave bus
);
  localparam int SW = 4 * (DIGITS + 1);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  logic [0:0]       state;
  logic [WIDTH-1:0] operand;
  logic [WIDTH-1:0] operand_nxt;
  logic [SW-1:0]    scratch;
  logic [SW-1:0]    scratch_adj;
  logic [SW-1:0]    scratch_nxt;
  logic [CW-1:0]    cnt;
  logic             last_id;
  logic             grant_any;
  logic             grant_id;

  // On contention the requester that was not served last wins.
  assign grant_any = bus.req0 | bus.req1;
  assign grant_id  = bus.req1 & (~bus.req0 | ~last_id);

  assign bus.busy = (state == SHIFT);

  // NOTE: every always_comb output gets a full default first, so no path can leave it unassigned and infer a latch.
  always_comb begin
    scratch_adj = scratch;
    for (int d = 0; d <= DIGITS; d++) begin
      if (scratch[4*d +: 4] >= 4'd5) begin
        scratch_adj[4*d +: 4] = scratch[4*d +: 4] + 4'd3;
      end
    end
    {scratch_nxt, operand_nxt} = {scratch_adj, operand} << 1;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      operand     <= '0;
      scratch     <= '0;
      cnt         <= '0;
      last_id     <= 1'b1;
      bus.ack0    <= 1'b0;
      bus.ack1    <= 1'b0;
      bus.done    <= 1'b0;
      bus.done_id <= 1'b0;
      bus.bcd_out <= '0;
      bus.ovf     <= 1'b0;
    end else begin
      bus.ack0 <= 1'b0;
      bus.ack1 <= 1'b0;
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_any) begin
            operand  <= grant_id ? bus.bin1 : bus.bin0;
            scratch  <= '0;
            cnt      <= '0;
            last_id  <= grant_id;
            bus.ack0 <= ~grant_id;
            bus.ack1 <= grant_id;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          operand <= operand_nxt;
          scratch <= scratch_nxt;
          cnt     <= cnt + 1'b1;
          if (cnt == LAST_ITER) begin
            bus.done    <= 1'b1;
            bus.done_id <= last_id;
            // A nonzero top scratch digit means the value does not fit in DIGITS digits.
            if (scratch_nxt[SW-1 -: 4] != 4'd0) begin
              bus.bcd_out <= {DIGITS{4'h9}};
              bus.ovf     <= 1'b1;
            end else begin
              bus.bcd_out <= scratch_nxt[4*DIGITS-1:0];
              bus.ovf     <= 1'b0;
            end
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bcd_convert_arbiter.sv
// Randomized self-checking bench for bcd_convert_arbiter.
// Expected results come from decimal arithmetic and a round-robin rule, not from the engine's algorithm.
module tb_bcd_convert_arbiter;
  localparam int WIDTH  = 20;
  localparam int DIGITS = 6;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  bit   model_last;

  bcd_convert_arbiter_if #(.WIDTH(WIDTH), .DIGITS(DIGITS)) bus ();

  bcd_convert_arbiter #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time (checks=%0d errors=%0d)", checks, errors);
    $fatal(1, "watchdog expired");
  end

  function automatic int unsigned max_value();
    int unsigned lim = 1;
    for (int d = 0; d < DIGITS; d++) lim = lim * 10;
    return lim - 1;
  endfunction

  function automatic logic [4*DIGITS-1:0] model_bcd(input int unsigned v);
    logic [4*DIGITS-1:0] r;
    int unsigned t;
    if (v > max_value()) return {DIGITS{4'h9}};
    r = '0;
    t = v;
    for (int d = 0; d < DIGITS; d++) begin
      r[4*d +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic logic model_ovf(input int unsigned v);
    return v > max_value();
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    model_last = 1'b1;
  endtask

  // Called at a negedge with requests already driven; the next rising edge is the grant edge.
  task automatic serve(input bit r0, input bit r1, input bit drop, input string tag);
    bit          exp_id;
    int unsigned v;
    bit          bad;
    int          bad_cycle;
    logic [3:0]  bad_sig;
    exp_id = (r0 && r1) ? ~model_last : r1;
    v = 32'(exp_id ? bus.bin1 : bus.bin0);
    @(negedge clk);
    checks++;
    if (bus.ack0 !== !exp_id || bus.ack1 !== exp_id || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL %s grant: ack0=%b ack1=%b busy=%b, required ack0=%b ack1=%b busy=1",
               tag, bus.ack0, bus.ack1, bus.busy, !exp_id, exp_id);
    end
    model_last = exp_id;
    if (exp_id) bus.bin1 = 20'($urandom);
    else        bus.bin0 = 20'($urandom);
    if (drop) begin
      if (exp_id) bus.req1 = 1'b0;
      else        bus.req0 = 1'b0;
    end
    bad = 1'b0;
    bad_cycle = 0;
    bad_sig = '0;
    for (int i = 1; i < WIDTH; i++) begin
      @(negedge clk);
      if (!bad && (bus.done !== 1'b0 || bus.ack0 !== 1'b0 || bus.ack1 !== 1'b0 || bus.busy !== 1'b1)) begin
        bad = 1'b1;
        bad_cycle = i;
        bad_sig = {bus.done, bus.ack0, bus.ack1, bus.busy};
      end
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL %s shift: cycle %0d after ack {done,ack0,ack1,busy}=%b, required 0001",
               tag, bad_cycle, bad_sig);
    end
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b1 || bus.done_id !== exp_id || bus.bcd_out !== model_bcd(v) ||
        bus.ovf !== model_ovf(v) || bus.busy !== 1'b0 || bus.ack0 !== 1'b0 || bus.ack1 !== 1'b0) begin
      errors++;
      $display("FAIL %s result: done=%b id=%b bcd=%h ovf=%b busy=%b, required done=1 id=%b bcd=%h ovf=%b busy=0 (operand %0d)",
               tag, bus.done, bus.done_id, bus.bcd_out, bus.ovf, bus.busy,
               exp_id, model_bcd(v), model_ovf(v), v);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    bus.bin0 = '0;
    bus.bin1 = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.ack0 !== 1'b0 || bus.ack1 !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0 ||
        bus.done_id !== 1'b0 || bus.bcd_out !== '0 || bus.ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: ack0=%b ack1=%b busy=%b done=%b id=%b bcd=%h ovf=%b, required all zero",
               bus.ack0, bus.ack1, bus.busy, bus.done, bus.done_id, bus.bcd_out, bus.ovf);
    end
    reset = 1'b1;
    model_last = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.ack0 !== 1'b0 || bus.ack1 !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL idle_hold: busy=%b ack0=%b ack1=%b done=%b, required all zero",
               bus.busy, bus.ack0, bus.ack1, bus.done);
    end
  endtask

  task automatic test_single();
    bus.bin0 = 20'd123456;
    bus.req0 = 1'b1;
    serve(1'b1, 1'b0, 1'b1, "single");
  endtask

  task automatic test_simultaneous();
    apply_reset();
    bus.bin0 = 20'd999999;
    bus.bin1 = 20'd0;
    bus.req0 = 1'b1;
    bus.req1 = 1'b1;
    serve(1'b1, 1'b1, 1'b1, "simul_first");
    serve(1'b0, 1'b1, 1'b1, "simul_second");
  endtask

  task automatic test_saturation();
    bus.bin1 = 20'hFFFFF;
    bus.req1 = 1'b1;
    serve(1'b0, 1'b1, 1'b1, "saturate");
    bus.bin1 = 20'd42;
    bus.req1 = 1'b1;
    serve(1'b0, 1'b1, 1'b1, "after_saturate");
  endtask

  task automatic test_fairness();
    bus.bin0 = 20'($urandom);
    bus.bin1 = 20'($urandom);
    bus.req0 = 1'b1;
    bus.req1 = 1'b1;
    for (int i = 0; i < 6; i++) serve(1'b1, 1'b1, 1'b0, $sformatf("fair%0d", i));
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
  endtask

  task automatic test_withdraw();
    int unsigned v;
    bit          bad;
    bus.bin0 = 20'($urandom_range(1, 999999));
    v = 32'(bus.bin0);
    bus.req0 = 1'b1;
    bus.req1 = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.ack0 !== 1'b1 || bus.ack1 !== 1'b0) begin
      errors++;
      $display("FAIL withdraw_grant: ack0=%b ack1=%b, required ack0=1 ack1=0", bus.ack0, bus.ack1);
    end
    bus.req0 = 1'b0;
    model_last = 1'b0;
    bad = 1'b0;
    for (int i = 1; i < WIDTH; i++) begin
      @(negedge clk);
      if (bus.ack1 !== 1'b0 || bus.done !== 1'b0) bad = 1'b1;
      if (i == 4)  bus.req1 = 1'b1;
      if (i == 12) bus.req1 = 1'b0;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL withdraw_ignored: ack1 or done rose during conversion, required both 0");
    end
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b1 || bus.done_id !== 1'b0 || bus.bcd_out !== model_bcd(v)) begin
      errors++;
      $display("FAIL withdraw_result: done=%b id=%b bcd=%h, required done=1 id=0 bcd=%h",
               bus.done, bus.done_id, bus.bcd_out, model_bcd(v));
    end
    bad = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (bus.ack1 !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL withdraw_idle: ack1=%b busy=%b done=%b after withdrawal, required all 0",
               bus.ack1, bus.busy, bus.done);
    end
  endtask

  task automatic test_reset_mid();
    bit bad;
    bus.bin0 = 20'd5;
    bus.req0 = 1'b1;
    bus.req1 = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.ack0 !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_grant: ack0=%b, required 1", bus.ack0);
    end
    repeat (10) @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (bus.ack0 !== 1'b0 || bus.ack1 !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0 ||
        bus.done_id !== 1'b0 || bus.bcd_out !== '0 || bus.ovf !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_async: ack0=%b ack1=%b busy=%b done=%b id=%b bcd=%h ovf=%b, required all zero",
               bus.ack0, bus.ack1, bus.busy, bus.done, bus.done_id, bus.bcd_out, bus.ovf);
    end
    bad = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL rstmid_hold: done or busy rose while in reset, required 0");
    end
    reset = 1'b1;
    model_last = 1'b1;
    serve(1'b1, 1'b0, 1'b1, "rstmid_resume");
  endtask

  task automatic test_random();
    bit r0;
    bit r1;
    for (int n = 0; n < 10; n++) begin
      r0 = 1'($urandom);
      r1 = 1'($urandom);
      if (!r0 && !r1) r0 = 1'b1;
      bus.bin0 = (n % 3 == 0) ? 20'($urandom) : 20'($urandom_range(0, 999999));
      bus.bin1 = (n % 4 == 1) ? 20'($urandom) : 20'($urandom_range(0, 999999));
      bus.req0 = r0;
      bus.req1 = r1;
      if (r0 && r1) begin
        serve(1'b1, 1'b1, 1'b1, $sformatf("rand%0d_a", n));
        serve(!model_last, model_last ? 1'b0 : 1'b1, 1'b1, $sformatf("rand%0d_b", n));
      end else begin
        serve(r0, r1, 1'b1, $sformatf("rand%0d", n));
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_saturation();
    test_fairness();
    test_withdraw();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
